// File: rtl/stack_transfer_sequencer_if.sv
// Decoder-side request and memory/register-file control bundle for the
// PUSH/POP list sequencer.
interface stack_transfer_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LIST_WIDTH = 9
);
  logic                  start;
  logic                  is_pop;
  logic [LIST_WIDTH-1:0] register_list;
  logic [DATA_WIDTH-1:0] current_SP;
  logic [1:0]            control;
  logic [3:0]            reg_index;
  logic [3:0]            wb_index;
  logic                  reg_write_enable;
  logic                  mem_write_enable;
  logic                  busy;
  logic                  done;
  logic                  stack_fault;

  modport master (
    output start, is_pop, register_list, current_SP,
    input  control, reg_index, wb_index, reg_write_enable,
           mem_write_enable, busy, done, stack_fault
  );

  modport slave (
    input  start, is_pop, register_list, current_SP,
    output control, reg_index, wb_index, reg_write_enable,
           mem_write_enable, busy, done, stack_fault
  );
endinterface

// File: rtl/stack_transfer_sequencer.sv
// Breaks a Thumb PUSH/POP register list into one stack word per cycle and
// stalls the core until the list is exhausted.
module stack_transfer_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    LIST_WIDTH = 9,
  parameter logic [3:0]            LR_INDEX   = 4'd14,
  parameter logic [3:0]            PC_INDEX   = 4'd15,
  parameter logic [DATA_WIDTH-1:0] EMPTY_SP   = '1
) (
  input  logic                        clock,
  input  logic                        reset,
  stack_transfer_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_POP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic [LIST_WIDTH-1:0] r_pending;
  logic                  r_wb_vld;
  logic [3:0]            r_wb_idx;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fault;

  logic [LIST_WIDTH-1:0] w_hi_mask;
  logic [3:0]            w_hi_idx;
  logic [LIST_WIDTH-1:0] w_lo_mask;
  logic [3:0]            w_lo_idx;
  logic [LIST_WIDTH-1:0] w_push_left;
  logic [LIST_WIDTH-1:0] w_pop_left;
  logic                  w_underflow;

  // Priority pick: push takes the highest pending bit, pop the lowest; the
  // top list bit stands for LR on push and PC on pop.
  always_comb begin
    w_hi_mask = '0;
    w_hi_idx  = '0;
    w_lo_mask = '0;
    w_lo_idx  = '0;
    for (int i = 0; i < LIST_WIDTH; i++) begin
      if (r_pending[i]) begin
        w_hi_mask    = '0;
        w_hi_mask[i] = 1'b1;
        w_hi_idx     = (i == LIST_WIDTH - 1) ? LR_INDEX : 4'(i);
      end
    end
    for (int i = LIST_WIDTH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_lo_mask    = '0;
        w_lo_mask[i] = 1'b1;
        w_lo_idx     = (i == LIST_WIDTH - 1) ? PC_INDEX : 4'(i);
      end
    end
  end

  assign w_push_left = r_pending & ~w_hi_mask;
  assign w_pop_left  = r_pending & ~w_lo_mask;

  // The empty check must see the SP of the issuing cycle, since the address
  // handler moves SP after every popped word.
  assign w_underflow = (r_state == ST_POP) && (bus.current_SP == EMPTY_SP);

  assign bus.control          = (r_state == ST_PUSH)                 ? 2'd1 :
                                (r_state == ST_POP && !w_underflow)  ? 2'd2 : 2'd0;
  assign bus.reg_index        = (r_state == ST_PUSH) ? w_hi_idx : 4'd0;
  assign bus.mem_write_enable = (r_state == ST_PUSH);
  assign bus.reg_write_enable = r_wb_vld;
  assign bus.wb_index         = r_wb_idx;
  assign bus.busy             = r_busy;
  assign bus.done             = r_done;
  assign bus.stack_fault      = r_fault;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_wb_vld  <= 1'b0;
      r_wb_idx  <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_wb_vld <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_pending <= bus.register_list;
            r_busy    <= 1'b1;
            if (bus.register_list == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= bus.is_pop ? ST_POP : ST_PUSH;
            end
          end
        end

        ST_PUSH: begin
          r_pending <= w_push_left;
          if (w_push_left == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end

        // Writeback of the previous word rides along with the next issue.
        ST_POP: begin
          if (w_underflow) begin
            r_pending <= '0;
            r_state   <= ST_DONE;
            r_done    <= 1'b1;
            r_fault   <= 1'b1;
          end else begin
            r_wb_vld  <= 1'b1;
            r_wb_idx  <= w_lo_idx;
            r_pending <= w_pop_left;
            if (w_pop_left == '0) begin
              r_state <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_pending <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_transfer_sequencer.sv
// Scoreboard bench: each operation queues its per-cycle expected outputs,
// a monitor pops one record per clock and compares.
`timescale 1ns/100ps
module tb_stack_transfer_sequencer;
  localparam int DW = 32;
  localparam int LW = 9;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  stack_transfer_sequencer_if #(.DATA_WIDTH(DW), .LIST_WIDTH(LW)) bus ();

  stack_transfer_sequencer #(
    .DATA_WIDTH(DW), .LIST_WIDTH(LW), .LR_INDEX(4'd14), .PC_INDEX(4'd15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string      tag;
    logic [1:0] ctrl;
    logic [3:0] ri;
    logic       mwe;
    logic [3:0] wbi;
    logic       rwe;
    logic       busy;
    logic       done;
    logic       flt;
    logic       strict;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [1:0] c, input logic [3:0] ri,
                            input logic mwe, input logic [3:0] wbi, input logic rwe,
                            input logic busy, input logic done, input logic flt,
                            input logic strict);
    exp_t e;
    e.tag = tag; e.ctrl = c; e.ri = ri; e.mwe = mwe; e.wbi = wbi; e.rwe = rwe;
    e.busy = busy; e.done = done; e.flt = flt; e.strict = strict;
    sb.push_back(e);
  endtask

  always @(posedge clock) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".ctrl"}, 32'(bus.control), 32'(e.ctrl));
      check({e.tag, ".mwe"},  32'(bus.mem_write_enable), 32'(e.mwe));
      check({e.tag, ".rwe"},  32'(bus.reg_write_enable), 32'(e.rwe));
      check({e.tag, ".busy"}, 32'(bus.busy), 32'(e.busy));
      check({e.tag, ".done"}, 32'(bus.done), 32'(e.done));
      check({e.tag, ".flt"},  32'(bus.stack_fault), 32'(e.flt));
      if (e.mwe || e.strict) check({e.tag, ".ri"},  32'(bus.reg_index), 32'(e.ri));
      if (e.rwe || e.strict) check({e.tag, ".wbi"}, 32'(bus.wb_index), 32'(e.wbi));
    end
  end

  // Called mid-cycle; returns mid-cycle after the start edge.
  task automatic start_op(input logic pop, input logic [LW-1:0] list);
    bus.start = 1'b1;
    bus.is_pop = pop;
    bus.register_list = list;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, ".drain"}, 32'(sb.size()), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.is_pop = 1'b0;
    bus.register_list = '0;
    bus.current_SP = 32'h0000_17FF;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    expect_cyc("rst", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 1);
    @(negedge clock);
    reset = 1'b0;
    expect_cyc("post_rst", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 1);
    wait_drain("rst");

    // PUSH r0, r1, LR
    expect_cyc("push1.c1", 2'd1, 4'd14, 1, 4'd0, 0, 1, 0, 0, 0);
    expect_cyc("push1.c2", 2'd1, 4'd1,  1, 4'd0, 0, 1, 0, 0, 0);
    expect_cyc("push1.c3", 2'd1, 4'd0,  1, 4'd0, 0, 1, 0, 0, 0);
    expect_cyc("push1.c4", 2'd0, 4'd0,  0, 4'd0, 0, 1, 1, 0, 0);
    expect_cyc("push1.c5", 2'd0, 4'd0,  0, 4'd0, 0, 0, 0, 0, 0);
    start_op(1'b0, 9'h103);
    wait_drain("push1");

    // POP r0, r7, PC
    expect_cyc("pop1.c1", 2'd2, 4'd0, 0, 4'd0,  0, 1, 0, 0, 0);
    expect_cyc("pop1.c2", 2'd2, 4'd0, 0, 4'd0,  1, 1, 0, 0, 0);
    expect_cyc("pop1.c3", 2'd2, 4'd0, 0, 4'd7,  1, 1, 0, 0, 0);
    expect_cyc("pop1.c4", 2'd0, 4'd0, 0, 4'd15, 1, 1, 0, 0, 0);
    expect_cyc("pop1.c5", 2'd0, 4'd0, 0, 4'd0,  0, 1, 1, 0, 0);
    expect_cyc("pop1.c6", 2'd0, 4'd0, 0, 4'd0,  0, 0, 0, 0, 0);
    start_op(1'b1, 9'h181);
    wait_drain("pop1");

    // POP r0..r3, stack runs empty from cycle 3
    expect_cyc("uflow.c1", 2'd2, 4'd0, 0, 4'd0, 0, 1, 0, 0, 0);
    expect_cyc("uflow.c2", 2'd2, 4'd0, 0, 4'd0, 1, 1, 0, 0, 0);
    expect_cyc("uflow.c3", 2'd0, 4'd0, 0, 4'd1, 1, 1, 0, 0, 0);
    expect_cyc("uflow.c4", 2'd0, 4'd0, 0, 4'd0, 0, 1, 1, 1, 0);
    expect_cyc("uflow.c5", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0);
    expect_cyc("uflow.c6", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0);
    bus.start = 1'b1;
    bus.is_pop = 1'b1;
    bus.register_list = 9'h00F;
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1 bus.current_SP = 32'hFFFF_FFFF;
    wait_drain("uflow");
    bus.current_SP = 32'h0000_17FF;

    // Empty list, plus a start during DONE that must be ignored
    expect_cyc("empty.c1", 2'd0, 4'd0, 0, 4'd0, 0, 1, 1, 0, 0);
    expect_cyc("empty.c2", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0);
    expect_cyc("empty.c3", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0);
    expect_cyc("empty.c4", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0);
    start_op(1'b0, 9'h000);
    start_op(1'b0, 9'h0FF);
    wait_drain("empty");

    // Reset in cycle 2 of a 4-word POP
    expect_cyc("rstpop.c1", 2'd2, 4'd0, 0, 4'd0, 0, 1, 0, 0, 0);
    expect_cyc("rstpop.c2", 2'd2, 4'd0, 0, 4'd0, 1, 1, 0, 0, 0);
    expect_cyc("rstpop.c3", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 1);
    expect_cyc("rstpop.c4", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 1);
    start_op(1'b1, 9'h00F);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    wait_drain("rstpop");

    expect_cyc("push2.c1", 2'd1, 4'd0, 1, 4'd0, 0, 1, 0, 0, 0);
    expect_cyc("push2.c2", 2'd0, 4'd0, 0, 4'd0, 0, 1, 1, 0, 0);
    expect_cyc("push2.c3", 2'd0, 4'd0, 0, 4'd0, 0, 0, 0, 0, 0);
    start_op(1'b0, 9'h001);
    wait_drain("push2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
